// File: rtl/usb20sr_oci_dct_pkg.sv
// Shared definitions for the OCI data-capture-trace (DCT) packer:
// frame geometry, atom codes, accumulator states and frame field layout.
package usb20sr_oci_dct_pkg;

  // Frame geometry: 15 two-bit atoms packed into a 30-bit buffer.
  localparam int DCT_ATOMS = 15;
  localparam int DCT_BUF_W = 2 * DCT_ATOMS;
  localparam int DCT_CNT_W = 4;
  localparam int DCT_FRM_W = DCT_CNT_W + DCT_BUF_W;

  // Field offsets inside frm_data = {count, buffer}.
  localparam int FRM_BUF_LSB = 0;
  localparam int FRM_BUF_MSB = FRM_BUF_LSB + DCT_BUF_W - 1;
  localparam int FRM_CNT_LSB = FRM_BUF_MSB + 1;
  localparam int FRM_CNT_MSB = FRM_CNT_LSB + DCT_CNT_W - 1;

  // Atom codes emitted by the CPU trace logic.
  typedef enum logic [1:0] {
    ATOM_NONE  = 2'd0,
    ATOM_LOAD  = 2'd1,
    ATOM_STORE = 2'd2,
    ATOM_ADDR  = 2'd3
  } dct_atom_e;

  // Accumulator occupancy states.
  typedef enum logic [1:0] {
    ACC_EMPTY     = 2'd0,
    ACC_FILLING   = 2'd1,
    ACC_FULL_WAIT = 2'd2
  } acc_state_e;

  // Assemble a frame word from an atom count and a packed buffer.
  function automatic logic [DCT_FRM_W-1:0] dct_pack_frame(
    input logic [DCT_CNT_W-1:0] cnt,
    input logic [DCT_BUF_W-1:0] buffer
  );
    logic [DCT_FRM_W-1:0] f;
    f = '0;
    f[FRM_CNT_MSB:FRM_CNT_LSB] = cnt;
    f[FRM_BUF_MSB:FRM_BUF_LSB] = buffer;
    return f;
  endfunction

endpackage

// File: rtl/usb20sr_oci_dct_hold.sv
// One-entry valid/ready holding register for completed DCT frames.
// A load is only issued by the packer when the entry is free (empty, or
// being accepted in the same cycle), so a load always wins over a drain.
module usb20sr_oci_dct_hold
  import usb20sr_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [DCT_FRM_W-1:0] data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [DCT_FRM_W-1:0] data_o
);

  logic                 valid_q, valid_d;
  logic [DCT_FRM_W-1:0] data_q, data_d;

  // Next entry state: refill on load, otherwise drop valid once accepted;
  // data is only replaced by a load so it stays stable while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers; reset discards any held frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/usb20sr_refdes_cpu_qsys_gen2_oci_dct_packer.sv
// DCT atom packer: accumulates 2-bit trace atoms into frames of up to 15
// atoms, hands completed frames to a one-entry holding register, and
// signals test_has_ended after an end-of-test drain.
// Optional feature macro: USB20SR_DCT_DROP_CNT_EN adds a saturating
// drop counter exposed on the drop_cnt port.
module usb20sr_refdes_cpu_qsys_gen2_oci_dct_packer
  import usb20sr_oci_dct_pkg::*;
#(
  parameter int ATOMS  = 15,
  parameter int DROP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 atom_valid,
  input  logic [1:0]           atom,
  input  logic                 flush,
  input  logic                 test_ending,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 frm_valid,
  input  logic                 frm_ready,
  output logic [DCT_FRM_W-1:0] frm_data,
  output logic                 dropped,
`ifdef USB20SR_DCT_DROP_CNT_EN
  output logic [DROP_W-1:0]    drop_cnt,
`endif
  output logic                 test_has_ended
);

  localparam logic [DCT_CNT_W-1:0] FULL_CNT = DCT_CNT_W'(ATOMS);

  // Accumulator and control state.
  logic [DCT_BUF_W-1:0] buf_q, buf_d;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d;
  acc_state_e           st_q, st_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 dropped_q, dropped_d;
  logic                 ended_q, ended_d;

  // Per-cycle decisions.
  dct_atom_e            atom_c;
  logic                 hold_free;
  logic                 accept;
  logic                 drop;
  logic                 flush_req;
  logic                 xfer;
  logic [DCT_CNT_W-1:0] post_cnt;
  logic [DCT_BUF_W-1:0] post_buf;
  logic [DCT_FRM_W-1:0] frame;

  assign atom_c = dct_atom_e'(atom);

  // Accept/drop, post-accept accumulator view, and transfer decision.
  // The transfer looks at the post-accept values so an atom arriving in
  // the same cycle as a flush or the 15th slot rides in that frame.
  always_comb begin
    hold_free = !frm_valid || frm_ready;
    accept    = atom_valid && (st_q != ACC_FULL_WAIT);
    drop      = atom_valid && (st_q == ACC_FULL_WAIT);
    post_cnt  = cnt_q + {{(DCT_CNT_W-1){1'b0}}, accept};
    post_buf  = accept ? {buf_q[DCT_BUF_W-3:0], atom_c} : buf_q;
    flush_req = flush || test_ending || flush_pend_q;
    xfer      = hold_free &&
                ((post_cnt == FULL_CNT) || (flush_req && (post_cnt != '0)));
    frame     = dct_pack_frame(post_cnt, post_buf);
  end

  // Next accumulator, state and sticky-flag values.
  always_comb begin
    cnt_d        = post_cnt;
    buf_d        = post_buf;
    st_d         = st_q;
    flush_pend_d = (flush_pend_q || flush) && !xfer && (post_cnt != '0);
    dropped_d    = dropped_q || drop;
    ended_d      = ended_q ||
                   (test_ending && (cnt_q == '0) && !frm_valid && !accept);
    if (xfer) begin
      cnt_d = '0;
      buf_d = '0;
      st_d  = ACC_EMPTY;
    end else if (post_cnt == FULL_CNT) begin
      st_d  = ACC_FULL_WAIT;
    end else if (post_cnt != '0) begin
      st_d  = ACC_FILLING;
    end else begin
      st_d  = ACC_EMPTY;
    end
  end

  // Accumulator FSM and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      st_q         <= ACC_EMPTY;
      flush_pend_q <= 1'b0;
      dropped_q    <= 1'b0;
      ended_q      <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      st_q         <= st_d;
      flush_pend_q <= flush_pend_d;
      dropped_q    <= dropped_d;
      ended_q      <= ended_d;
    end
  end

`ifdef USB20SR_DCT_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q;

  // Saturating count of lost atoms; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_w;
  assign unused_drop_w = (DROP_W == 0);
`endif

  usb20sr_oci_dct_hold u_hold (
    .clk     (clk),
    .reset   (reset),
    .load_i  (xfer),
    .data_i  (frame),
    .ready_i (frm_ready),
    .valid_o (frm_valid),
    .data_o  (frm_data)
  );

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign dropped        = dropped_q;
  assign test_has_ended = ended_q;

endmodule
